// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Core-side reader of the instruction RAM. Issues one word address per
//   cycle to a registered-read RAM (1-cycle latency), captures the returned
//   word into a small prefetch FIFO, and presents the head word to the
//   decoder with a valid/ready handshake. Supports PC redirect with flush
//   and halt from the control unit.
//
//   Optional build macro: IFU_PERF_CNT_EN adds the fetch_cnt/stall_cnt
//   performance counters.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   fetch_en            0 blocks new requests; in-flight word still captured
//   iram_addr           RAM word address (direct copy of pc register)
//   iram_data           RAM read data, valid the cycle after the request
//   out_valid/out_ready handshake toward the decoder
//   out_instr/out_pc    FIFO head word and the address it came from
//   redirect_valid/pc   load new PC, flush FIFO and in-flight response
//   halt_req            stop fetching; halted stays set until redirect
//   halted              fetch stopped
//   fetch_cnt/stall_cnt (IFU_PERF_CNT_EN only) performance counters

module instr_fetch_unit #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] iram_addr,
  input  logic [DATA_W-1:0] iram_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              halted
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pend_pc;
  logic              rsp_pending;
  logic              halted_q;

  logic [DATA_W-1:0] mem_instr [DEPTH];
  logic [ADDR_W-1:0] mem_pc    [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [CNT_W-1:0]  credit_used;
  logic              issue;
  logic              push;
  logic              pop;

  // Credit counts the in-flight response so the FIFO can never overflow.
  // A pop in the same cycle is deliberately not credited, which keeps
  // out_ready out of the issue/address path.
  assign credit_used = count + CNT_W'(rsp_pending);
  assign issue = fetch_en && !halted_q && !redirect_valid && !halt_req &&
                 (credit_used < CNT_W'(DEPTH));

  assign push = rsp_pending && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;

  assign iram_addr = pc;
  assign out_valid = (count != '0);
  assign out_instr = mem_instr[rd_ptr];
  assign out_pc    = mem_pc[rd_ptr];
  assign halted    = halted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= ADDR_W'(RESET_PC);
      pend_pc     <= '0;
      rsp_pending <= 1'b0;
      halted_q    <= 1'b0;
    end else if (redirect_valid) begin
      pc          <= redirect_pc;
      rsp_pending <= 1'b0;
      halted_q    <= halt_req;
    end else begin
      rsp_pending <= issue;
      if (issue) begin
        pend_pc <= pc;
        pc      <= pc + 1'b1;
      end
      if (halt_req) halted_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= iram_data;
        mem_pc[wr_ptr]    <= pend_pc;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (push) fetch_cnt <= fetch_cnt + 32'd1;
      if (out_ready && !out_valid && !halted_q) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [15:0] iram_addr;
  logic [15:0] iram_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt_req;
  logic        halted;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] ram [0:65535];

  instr_fetch_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .iram_addr(iram_addr), .iram_data(iram_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .halted(halted)
`ifdef IFU_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // registered-read RAM, output register not reset
  always @(posedge clk) iram_data <= ram[iram_addr];

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        v;
    logic        chk_d;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] addr;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic redirect(input logic [15:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic drain_check(input logic [15:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] p;
      p = 16'(start + 16'(i));
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_pc", 32'(out_pc), 32'(p));
      chk("drain_instr", 32'(out_instr), 32'(ram[p]));
      step();
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < 11; i++) begin
      fetch_en  = tbl[i].fe;
      out_ready = tbl[i].rdy;
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].v));
      chk("tbl_addr", 32'(iram_addr), 32'(tbl[i].addr));
      if (tbl[i].chk_d) begin
        chk("tbl_pc", 32'(out_pc), 32'(tbl[i].pc));
        chk("tbl_instr", 32'(out_instr), 32'(tbl[i].instr));
      end
      step();
    end
    fetch_en = 1'b1;
`ifdef IFU_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, 32'd8);
    chk("stall_cnt", stall_cnt, 32'd4);
`endif
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 16'(32'h1000 + i);
    ram[0]   = 16'd5;
    ram[1]   = 16'd7;
    ram[2]   = 16'd29;
    ram[3]   = 16'd30;
    ram[234] = 16'd51;

    //          fe    rdy   v     chk_d pc     instr      addr
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0,     16'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0,     16'd1};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd0, 16'd5,     16'd2};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd1, 16'd7,     16'd3};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd2, 16'd29,    16'd4};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd3, 16'd30,    16'd5};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd4, 16'h1004,  16'd6};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd5, 16'h1005,  16'd6};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0,     16'd6};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0,     16'd7};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd6, 16'h1006,  16'd8};

    fetch_en       = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 16'd0;
    halt_req       = 1'b0;
    rst_n          = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", 32'(iram_addr), 32'd0);
    chk("rst_instr", 32'(out_instr), 32'd0);
    chk("rst_pc", 32'(out_pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    // cold start plus fetch_en gap
    do_reset();
    run_table();

    // backpressure: exactly DEPTH words buffered, no extra issue
    do_reset();
    out_ready = 1'b0;
    repeat (10) step();
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_pc", 32'(out_pc), 32'd0);
    chk("bp_instr", 32'(out_instr), 32'd5);
    chk("bp_addr", 32'(iram_addr), 32'd4);
    out_ready = 1'b1;
    drain_check(16'd0, 8);

    // redirect flush: 3 buffered (17..19), 20 in flight, pc=21
    out_ready = 1'b0;
    redirect(16'd17);
    repeat (4) step();
    chk("fl_pre_valid", 32'(out_valid), 32'd1);
    chk("fl_pre_pc", 32'(out_pc), 32'd17);
    chk("fl_pre_addr", 32'(iram_addr), 32'd21);
    out_ready = 1'b1;
    redirect(16'd48);
    chk("fl_r1_valid", 32'(out_valid), 32'd0);
    chk("fl_r1_addr", 32'(iram_addr), 32'd48);
    step();
    chk("fl_r2_valid", 32'(out_valid), 32'd0);
    chk("fl_r2_addr", 32'(iram_addr), 32'd49);
    step();
    drain_check(16'd48, 5);

    // halt at pc=235, word 234 still in flight
    redirect(16'd230);
    step();
    step();
    drain_check(16'd230, 3);
    chk("h_addr_pre", 32'(iram_addr), 32'd235);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("h_halted", 32'(halted), 32'd1);
    chk("h_valid", 32'(out_valid), 32'd1);
    chk("h_pc", 32'(out_pc), 32'd234);
    chk("h_instr", 32'(out_instr), 32'd51);
    chk("h_addr", 32'(iram_addr), 32'd235);
    step();
    chk("h_empty", 32'(out_valid), 32'd0);
    repeat (3) step();
    chk("h_hold_addr", 32'(iram_addr), 32'd235);
    chk("h_hold_halted", 32'(halted), 32'd1);
    chk("h_hold_valid", 32'(out_valid), 32'd0);
    redirect(16'd0);
    chk("h_clr_halted", 32'(halted), 32'd0);
    chk("h_clr_addr", 32'(iram_addr), 32'd0);
    step();
    step();
    drain_check(16'd0, 4);

    // address wrap
    redirect(16'hFFFE);
    step();
    step();
    drain_check(16'hFFFE, 4);

    // async reset with FIFO full, then cold start again
    out_ready = 1'b0;
    repeat (10) step();
    chk("ar_full_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_addr", 32'(iram_addr), 32'd0);
    chk("ar_pc", 32'(out_pc), 32'd0);
    chk("ar_instr", 32'(out_instr), 32'd0);
    step();
    rst_n = 1'b1;
    run_table();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
